// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush control for the IF/ID and ID/EX pipeline registers
//
// Purpose:
//   Generates the zero-latency stall and flush controls for a 5-stage RISC-V
//   pipeline. It covers load-use bubbles (LOAD_STALL_CYCLES per hazard),
//   taken branch/jump squashes, and an ecall drain-then-halt sequence. It also
//   keeps saturating stall and flush event counters.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-low reset
//   id_rs1_index/id_rs2_index source registers of the instruction in ID
//   id_use_rs1/id_use_rs2    ID instruction actually reads rs1/rs2
//   ex_rd_index, ex_wb_en,   destination and writeback controls held in ID/EX
//   ex_wb_sel                (wb_sel = 1 means the result is load data)
//   ex_ecall_sig             ecall currently in EX
//   ex_jb_taken              branch/jump resolved taken in EX
//   pc_stall, fd_stall       hold PC / hold IF/ID (combinational)
//   fd_flush, de_flush       clear IF/ID / flush ID/EX control fields (combinational)
//   halt                     core halted after ecall drained (registered)
//   stall_cnt, flush_cnt     saturating bubble-cycle / taken-jb counters (registered)

module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_index,
  input  logic [4:0]       id_rs2_index,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd_index,
  input  logic             ex_wb_en,
  input  logic             ex_wb_sel,
  input  logic             ex_ecall_sig,
  input  logic             ex_jb_taken,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] LS_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] DR_INIT = 4'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_stall_ctr;
  logic [3:0]       r_drain_ctr;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  // A load writing x0 never produces a value a consumer could depend on.
  assign w_rs1_hit  = id_use_rs1 & (id_rs1_index == ex_rd_index);
  assign w_rs2_hit  = id_use_rs2 & (id_rs2_index == ex_rd_index);
  assign w_load_use = ex_wb_en & ex_wb_sel & (ex_rd_index != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // Controls are decoded from the state and live inputs so the pipeline
  // registers react in the same cycle the hazard is seen.
  always_comb begin
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_ecall_sig) begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (ex_jb_taken) begin
          // The younger instruction is squashed, so a coincident load-use is moot.
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (w_load_use) begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
        end
      end
      LSTALL: begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_flush = 1'b1;
      end
      DRAIN, HALTED: begin
        pc_stall = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
      end
      default: begin
        pc_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_stall_ctr <= 4'd0;
      r_drain_ctr <= 4'd0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_ecall_sig) begin
            r_state     <= DRAIN;
            r_drain_ctr <= DR_INIT;
          end else if (ex_jb_taken) begin
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
          end else if (w_load_use) begin
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            // The RUN cycle itself is the first bubble; LSTALL supplies the rest.
            if (LOAD_STALL_CYCLES > 1) begin
              r_state     <= LSTALL;
              r_stall_ctr <= LS_INIT;
            end
          end
        end
        LSTALL: begin
          // EX holds a bubble here, so jb/ecall inputs are not looked at.
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          if (r_stall_ctr <= 4'd1) begin
            r_state     <= RUN;
            r_stall_ctr <= 4'd0;
          end else begin
            r_stall_ctr <= r_stall_ctr - 4'd1;
          end
        end
        DRAIN: begin
          if (r_drain_ctr == 4'd0) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end else begin
            r_drain_ctr <= r_drain_ctr - 4'd1;
          end
        end
        HALTED: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wb_en;
    logic       wb_sel;
    logic       ecall;
    logic       jb;
  } in_t;

  typedef struct {
    bit    sel;
    string tag;
    logic  pc;
    logic  fs;
    logic  ff;
    logic  de;
    logic  halt;
    int    sc;
    int    fc;
  } exp_t;

  logic clk;
  logic rst;
  in_t  in_a;
  in_t  in_b;

  logic        a_pc, a_fs, a_ff, a_de, a_halt;
  logic [31:0] a_sc, a_fc;
  logic        b_pc, b_fs, b_ff, b_de, b_halt;
  logic [3:0]  b_sc, b_fc;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_index(in_a.rs1), .id_rs2_index(in_a.rs2),
    .id_use_rs1(in_a.u1), .id_use_rs2(in_a.u2),
    .ex_rd_index(in_a.rd), .ex_wb_en(in_a.wb_en), .ex_wb_sel(in_a.wb_sel),
    .ex_ecall_sig(in_a.ecall), .ex_jb_taken(in_a.jb),
    .pc_stall(a_pc), .fd_stall(a_fs), .fd_flush(a_ff), .de_flush(a_de),
    .halt(a_halt), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_index(in_b.rs1), .id_rs2_index(in_b.rs2),
    .id_use_rs1(in_b.u1), .id_use_rs2(in_b.u2),
    .ex_rd_index(in_b.rd), .ex_wb_en(in_b.wb_en), .ex_wb_sel(in_b.wb_sel),
    .ex_ecall_sig(in_b.ecall), .ex_jb_taken(in_b.jb),
    .pc_stall(b_pc), .fd_stall(b_fs), .fd_flush(b_ff), .de_flush(b_de),
    .halt(b_halt), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic wb_en,
                             input logic wb_sel, input logic ecall, input logic jb);
    in_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.wb_en = wb_en; r.wb_sel = wb_sel; r.ecall = ecall; r.jb = jb;
    return r;
  endfunction

  task automatic push_exp(input bit sel, input string tag, input logic pc, input logic fs,
                          input logic ff, input logic de, input logic hl, input int sc,
                          input int fc);
    exp_t e;
    e.sel = sel; e.tag = tag; e.pc = pc; e.fs = fs; e.ff = ff; e.de = de;
    e.halt = hl; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    if (!e.sel) begin
      check({e.tag, ".pc_stall"}, 32'(a_pc), 32'(e.pc));
      check({e.tag, ".fd_stall"}, 32'(a_fs), 32'(e.fs));
      check({e.tag, ".fd_flush"}, 32'(a_ff), 32'(e.ff));
      check({e.tag, ".de_flush"}, 32'(a_de), 32'(e.de));
      check({e.tag, ".halt"}, 32'(a_halt), 32'(e.halt));
      check({e.tag, ".stall_cnt"}, a_sc, 32'(e.sc));
      check({e.tag, ".flush_cnt"}, a_fc, 32'(e.fc));
    end else begin
      check({e.tag, ".pc_stall"}, 32'(b_pc), 32'(e.pc));
      check({e.tag, ".fd_stall"}, 32'(b_fs), 32'(e.fs));
      check({e.tag, ".fd_flush"}, 32'(b_ff), 32'(e.ff));
      check({e.tag, ".de_flush"}, 32'(b_de), 32'(e.de));
      check({e.tag, ".halt"}, 32'(b_halt), 32'(e.halt));
      check({e.tag, ".stall_cnt"}, 32'(b_sc), 32'(e.sc));
      check({e.tag, ".flush_cnt"}, 32'(b_fc), 32'(e.fc));
    end
  endtask

  // Drive one cycle of inputs just after the edge and compare at the falling edge,
  // before the next rising edge commits the registered state.
  task automatic step(input bit sel, input in_t in, input string tag, input logic pc,
                      input logic fs, input logic ff, input logic de, input logic hl,
                      input int sc, input int fc);
    if (!sel) in_a = in; else in_b = in;
    push_exp(sel, tag, pc, fs, ff, de, hl, sc, fc);
    @(negedge clk);
    pop_compare();
    @(posedge clk);
    #1;
  endtask

  in_t idle;
  in_t lu_a;
  in_t lu_b;
  int  exp_sc;

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu_a = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    lu_b = mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    rst  = 1'b0;
    in_a = idle;
    in_b = idle;

    // Reset state of both instances.
    push_exp(1'b0, "rst_a", 0, 0, 0, 0, 0, 0, 0);
    push_exp(1'b1, "rst_b", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    pop_compare();
    pop_compare();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // LOAD_STALL_CYCLES = 1 instance.
    step(0, idle, "a_idle", 0, 0, 0, 0, 0, 0, 0);
    step(0, lu_a, "a_lu_rs1", 1, 1, 0, 1, 0, 0, 0);
    step(0, idle, "a_lu_done", 0, 0, 0, 0, 0, 1, 0);
    step(0, mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0), "a_rd_x0", 0, 0, 0, 0, 0, 1, 0);
    step(0, mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), "a_not_load", 0, 0, 0, 0, 0, 1, 0);
    step(0, mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1), "a_jb_over_lu", 0, 0, 1, 1, 0, 1, 0);
    step(0, idle, "a_after_jb", 0, 0, 0, 0, 0, 1, 1);
    step(0, mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1), "a_ecall", 1, 0, 1, 1, 0, 1, 1);
    step(0, idle, "a_drain1", 1, 0, 1, 1, 0, 1, 1);
    step(0, idle, "a_drain2", 1, 0, 1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, mk(5'(5 + i % 2), 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0,
                 1'($urandom_range(0, 1))),
           "a_halted", 1, 0, 1, 1, 1, 1, 1);
    end

    // Reset pulse clears halt and counters immediately.
    rst  = 1'b0;
    in_a = idle;
    #1;
    push_exp(0, "a_rst_halt", 0, 0, 0, 0, 0, 0, 0);
    pop_compare();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(0, idle, "a_post_rst", 0, 0, 0, 0, 0, 0, 0);

    // LOAD_STALL_CYCLES = 3, CNT_W = 4 instance; jb/ecall during LSTALL are ignored.
    step(1, lu_b, "b_lu_rs2_c1", 1, 1, 0, 1, 0, 0, 0);
    step(1, mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), "b_lu_c2", 1, 1, 0, 1, 0, 1, 0);
    step(1, mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0), "b_lu_c3", 1, 1, 0, 1, 0, 2, 0);
    step(1, idle, "b_back_run", 0, 0, 0, 0, 0, 3, 0);
    step(1, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), "b_jb", 0, 0, 1, 1, 0, 3, 0);
    step(1, idle, "b_after_jb", 0, 0, 0, 0, 0, 3, 1);

    // Counter saturation at 15 across 20 further load-use events.
    exp_sc = 3;
    for (int ev = 0; ev < 20; ev++) begin
      for (int k = 0; k < 3; k++) begin
        step(1, lu_b, "b_sat_stall", 1, 1, 0, 1, 0, exp_sc, 1);
        if (exp_sc < 15) exp_sc++;
      end
      step(1, idle, "b_sat_gap", 0, 0, 0, 0, 0, exp_sc, 1);
    end
    step(1, idle, "b_sat_final", 0, 0, 0, 0, 0, 15, 1);

    // Reset asserted mid-stall.
    step(1, lu_b, "b_pre_rst", 1, 1, 0, 1, 0, 15, 1);
    rst  = 1'b0;
    in_b = idle;
    #1;
    push_exp(1, "b_rst_mid", 0, 0, 0, 0, 0, 0, 0);
    pop_compare();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1, idle, "b_run_after_rst", 0, 0, 0, 0, 0, 0, 0);
    step(1, lu_b, "b_relu_c1", 1, 1, 0, 1, 0, 0, 0);
    step(1, idle, "b_relu_c2", 1, 1, 0, 1, 0, 1, 0);
    step(1, idle, "b_relu_c3", 1, 1, 0, 1, 0, 2, 0);
    step(1, idle, "b_relu_done", 0, 0, 0, 0, 0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit that generates the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers of the 5-stage RISC-V core. It inspects the instruction in decode and the instruction latched in the ID/EX register, and produces the following:
- load-use stalls, with configurable memory latency
- taken-branch/jump flushes
- an ecall drain-then-halt sequence
It also keeps saturating stall and flush performance counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
DRAIN_CYCLES, 2, cycles after ecall reaches EX before halt asserts (1..15), covering MEM and WB
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
id_rs1_index  in  5  rs1 of instruction in ID
id_rs2_index  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd_index  in  5  rd from ID/EX register
ex_wb_en  in  1  wb_en from ID/EX register
ex_wb_sel  in  1  wb_sel from ID/EX register (1 = load data)
ex_ecall_sig  in  1  ecall_sig from ID/EX register
ex_jb_taken  in  1  branch/jump resolved taken in EX
pc_stall  out  1  hold PC
fd_stall  out  1  hold IF/ID register
fd_flush  out  1  clear IF/ID register
de_flush  out  1  flush control fields of ID/EX register (drives its flush input)
halt  out  1  core halted after ecall
stall_cnt  out  CNT_W  load-use bubble cycles, saturating
flush_cnt  out  CNT_W  taken-jb flush events, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - state = RUN, stall counter = 0, drain counter = 0
  - halt = 0, stall_cnt = 0, flush_cnt = 0
  - with all inputs 0, pc_stall, fd_stall, fd_flush and de_flush are 0.
- Outputs pc_stall, fd_stall, fd_flush and de_flush are combinational from the state, the counters and the current inputs, with zero latency. halt, stall_cnt and flush_cnt are registered.
- Hazard detection:
  - load_use = ex_wb_en & ex_wb_sel & (ex_rd_index != 0) & ((id_use_rs1 & id_rs1_index == ex_rd_index) | (id_use_rs2 & id_rs2_index == ex_rd_index)).
  - rd = x0 never hazards.
- States: RUN, LSTALL, DRAIN, HALTED.
- RUN:
  - ex_ecall_sig: outputs pc_stall = 1, fd_flush = 1, de_flush = 1. Next state DRAIN, drain counter = DRAIN_CYCLES - 1.
  - else ex_jb_taken: outputs fd_flush = 1, de_flush = 1, pc_stall = 0. flush_cnt += 1. No stall, even if load_use is also true, because the younger instruction is squashed.
  - else load_use: outputs pc_stall = 1, fd_stall = 1, de_flush = 1. stall_cnt += 1. If LOAD_STALL_CYCLES > 1, next state LSTALL with stall counter = LOAD_STALL_CYCLES - 1.
  - else all outputs 0.
- LSTALL:
  - Outputs pc_stall = 1, fd_stall = 1, de_flush = 1. stall_cnt += 1. Stall counter decrements.
  - Return to RUN in the cycle after the counter reaches 1. The total bubble count is exactly LOAD_STALL_CYCLES.
  - EX holds a bubble during LSTALL, so ex_jb_taken and ex_ecall_sig are ignored there.
- DRAIN:
  - Outputs pc_stall = 1, fd_flush = 1, de_flush = 1.
  - Drain counter decrements. When it is 0, next state HALTED and halt <= 1.
  - Total cycles from ecall in EX to halt = 1 is DRAIN_CYCLES + 1 edges.
- HALTED:
  - halt = 1, pc_stall = 1, fd_flush = 1, de_flush = 1, held until reset.
  - Inputs are ignored and counters freeze.
- Priority when events coincide: ecall > jb_taken > load_use.
- Performance counters saturate at 2^CNT_W - 1 and never wrap.
- Reset asserted in any state, mid-stall or mid-drain, returns immediately to the reset values. The next hazard evaluation happens on the first edge after rst deasserts.
- fd_stall and fd_flush are never both 1 in the same cycle.

Test Plan:
- Reset, idle: rst low, then high with all inputs 0 → all outputs 0, stall_cnt = 0, flush_cnt = 0.
- Load-use on rs1: ex_wb_en = 1, ex_wb_sel = 1, ex_rd_index = 5, id_rs1_index = 5, id_use_rs1 = 1, LOAD_STALL_CYCLES = 1 → pc_stall, fd_stall and de_flush high for exactly 1 cycle, then stall_cnt = 1. Repeating with ex_rd_index = 0 gives no stall. Repeating with ex_wb_sel = 0 gives no stall.
- Multi-cycle stall: LOAD_STALL_CYCLES = 3, rs2 match on x7 → stall outputs high for 3 consecutive cycles, stall_cnt = 3, state returns to RUN.
- Branch beats load-use: ex_jb_taken = 1 and load_use = 1 in the same cycle → fd_flush = 1, de_flush = 1, pc_stall = 0, fd_stall = 0, flush_cnt = 1, stall_cnt = 0.
- Ecall drain: ex_ecall_sig = 1 with DRAIN_CYCLES = 2 → pc_stall and both flushes high from that cycle on. halt rises after 3 edges and stays high while random ex_jb_taken/load_use inputs are applied. Pulsing rst low clears halt.
- Saturation and reset mid-stall: CNT_W = 4 with 20 load-use events → stall_cnt = 15. rst asserted during LSTALL → outputs go to 0 immediately and state = RUN.
